sync_data_mem: RTL and testbench

SYNC_DATA_MEM -- requirements
Module: sync_data_mem

---
 rtl/sync_data_mem.sv | 116 +++++++++++
 tb/tb_sync_data_mem.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_data_mem.sv
// Word-organised 32-bit data memory with byte strobes, a fixed-latency read pipeline,
// optional same-cycle write-to-read forwarding and saturating access counters.
module sync_data_mem #(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned RD_LATENCY = 1,
    parameter bit          FWD_EN     = 1'b1,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_re,
    input  logic [31:0] data_raddr,
    input  logic        data_we,
    input  logic [31:0] data_waddr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_wstrb,
    output logic [31:0] data_rdata,
    output logic        data_rvalid,
    output logic        data_err,
    output logic [15:0] rd_cnt,
    output logic [15:0] wr_cnt
);

    localparam int unsigned DEPTH       = 2 ** DEPTH_LOG2;
    localparam logic [32:0] DEPTH_WORDS = 33'd1 << DEPTH_LOG2;
    localparam logic [29:0] BASE_WORD   = BASE_ADDR[31:2];

    logic [31:0] mem [DEPTH];

    logic [29:0] r_idx;
    logic [29:0] w_idx;
    logic        r_in_range;
    logic        w_in_range;
    logic        fwd_hit;
    logic [31:0] rd_word;
    logic [31:0] rd_result;
    logic        unused_addr_bits;

    logic [RD_LATENCY-1:0]       pipe_valid;
    logic [RD_LATENCY-1:0]       pipe_err;
    logic [RD_LATENCY-1:0][31:0] pipe_data;
    logic                        wr_err_q;

    // Byte offset bits never select anything; BASE_ADDR is word aligned so the
    // subtraction can be done on word indices directly.
    assign unused_addr_bits = ^{data_raddr[1:0], data_waddr[1:0]};

    always_comb begin
        r_idx      = data_raddr[31:2] - BASE_WORD;
        w_idx      = data_waddr[31:2] - BASE_WORD;
        r_in_range = ({3'b000, r_idx} < DEPTH_WORDS);
        w_in_range = ({3'b000, w_idx} < DEPTH_WORDS);
        fwd_hit    = FWD_EN && data_we && w_in_range && r_in_range && (w_idx == r_idx);
    end

    always_comb begin
        rd_word   = mem[r_idx[DEPTH_LOG2-1:0]];
        rd_result = rd_word;
        if (fwd_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (data_wstrb[b]) begin
                    rd_result[8*b +: 8] = data_wdata[8*b +: 8];
                end
            end
        end
    end

    // Storage is deliberately left out of reset so data survives a reset pulse.
    always_ff @(posedge clk) begin
        if (rst_n && data_we && w_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (data_wstrb[b]) begin
                    mem[w_idx[DEPTH_LOG2-1:0]][8*b +: 8] <= data_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_valid <= '0;
            pipe_err   <= '0;
            pipe_data  <= '0;
            wr_err_q   <= 1'b0;
        end else begin
            pipe_valid[0] <= data_re;
            pipe_err[0]   <= data_re && !r_in_range;
            pipe_data[0]  <= (data_re && r_in_range) ? rd_result : 32'h0;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_err[i]   <= pipe_err[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
            wr_err_q <= data_we && !w_in_range;
        end
    end

    assign data_rvalid = pipe_valid[RD_LATENCY-1];
    assign data_rdata  = pipe_data[RD_LATENCY-1];
    assign data_err    = pipe_err[RD_LATENCY-1] | wr_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_cnt <= 16'h0000;
            wr_cnt <= 16'h0000;
        end else begin
            if (data_re && (rd_cnt != 16'hFFFF)) begin
                rd_cnt <= rd_cnt + 16'd1;
            end
            if (data_we && w_in_range && (wr_cnt != 16'hFFFF)) begin
                wr_cnt <= wr_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_sync_data_mem.sv
// Scoreboard bench driving two differently parameterised sync_data_mem instances
// with the same logical access stream; each has its own reference model.
module tb_sync_data_mem;

    localparam int          A_DEPTH_LOG2 = 12;
    localparam int          A_LAT        = 1;
    localparam bit          A_FWD        = 1'b1;
    localparam logic [31:0] A_BASE       = 32'h0000_1000;
    localparam int          B_DEPTH_LOG2 = 4;
    localparam int          B_LAT        = 3;
    localparam bit          B_FWD        = 1'b0;
    localparam logic [31:0] B_BASE       = 32'h0000_0000;

    typedef struct packed {
        int          due;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        re;
    logic        we;
    logic [31:0] raddr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;

    logic [31:0] a_rdata, b_rdata;
    logic        a_rvalid, b_rvalid;
    logic        a_err, b_err;
    logic [15:0] a_rd_cnt, b_rd_cnt, a_wr_cnt, b_wr_cnt;

    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [31:0] mdl_mem [longint];
    int          mdl_rd [2];
    int          mdl_wr [2];
    logic        wr_err_now [2];
    int          edge_n = 0;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    sync_data_mem #(.DEPTH_LOG2(A_DEPTH_LOG2), .RD_LATENCY(A_LAT), .FWD_EN(A_FWD), .BASE_ADDR(A_BASE)) dut_a (
        .clk(clk), .rst_n(rst_n), .data_re(re), .data_raddr(raddr + A_BASE),
        .data_we(we), .data_waddr(waddr + A_BASE), .data_wdata(wdata), .data_wstrb(wstrb),
        .data_rdata(a_rdata), .data_rvalid(a_rvalid), .data_err(a_err),
        .rd_cnt(a_rd_cnt), .wr_cnt(a_wr_cnt)
    );

    sync_data_mem #(.DEPTH_LOG2(B_DEPTH_LOG2), .RD_LATENCY(B_LAT), .FWD_EN(B_FWD), .BASE_ADDR(B_BASE)) dut_b (
        .clk(clk), .rst_n(rst_n), .data_re(re), .data_raddr(raddr + B_BASE),
        .data_we(we), .data_waddr(waddr + B_BASE), .data_wdata(wdata), .data_wstrb(wstrb),
        .data_rdata(b_rdata), .data_rvalid(b_rvalid), .data_err(b_err),
        .rd_cnt(b_rd_cnt), .wr_cnt(b_wr_cnt)
    );

    function automatic longint key_of(input int k, input logic [29:0] idx);
        return (longint'(k) << 32) | longint'(idx);
    endfunction

    function automatic bit in_range(input int k, input logic [31:0] addr);
        longint words;
        words = (k == 0) ? (longint'(1) << A_DEPTH_LOG2) : (longint'(1) << B_DEPTH_LOG2);
        return longint'(addr[31:2]) < words;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Reference behaviour of instance k at the upcoming rising edge.
    task automatic modelEdge(input int k);
        exp_t        e;
        logic [31:0] stored;
        bit          fwd;
        int          lat;
        fwd = (k == 0) ? A_FWD : B_FWD;
        lat = (k == 0) ? A_LAT : B_LAT;
        if (!rst_n) begin
            if (k == 0) q_a.delete(); else q_b.delete();
            mdl_rd[k] = 0;
            mdl_wr[k] = 0;
            wr_err_now[k] = 1'b0;
            return;
        end
        if (re) begin
            e.due = edge_n + lat - 1;
            if (in_range(k, raddr)) begin
                stored = mdl_mem[key_of(k, raddr[31:2])];
                if (fwd && we && in_range(k, waddr) && (waddr[31:2] == raddr[31:2]))
                    stored = merge(stored, wdata, wstrb);
                e.data = stored;
                e.err  = 1'b0;
            end else begin
                e.data = 32'h0;
                e.err  = 1'b1;
            end
            if (k == 0) q_a.push_back(e); else q_b.push_back(e);
            if (mdl_rd[k] < 65535) mdl_rd[k]++;
        end
        wr_err_now[k] = we && !in_range(k, waddr);
        if (we && in_range(k, waddr)) begin
            stored = mdl_mem.exists(key_of(k, waddr[31:2])) ? mdl_mem[key_of(k, waddr[31:2])] : 32'h0;
            mdl_mem[key_of(k, waddr[31:2])] = merge(stored, wdata, wstrb);
            if (mdl_wr[k] < 65535) mdl_wr[k]++;
        end
    endtask

    task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s at edge %0d: observed=%h expected=%h", tag, edge_n, obs, expv);
        end
    endtask

    task automatic checkOutput(input int k);
        exp_t        e;
        logic        ev;
        logic [31:0] ed;
        logic        ee;
        string       n;
        ev = 1'b0;
        ed = 32'h0;
        ee = wr_err_now[k];
        n  = (k == 0) ? "a" : "b";
        if (k == 0) begin
            if (q_a.size() > 0 && q_a[0].due == edge_n) begin
                e = q_a.pop_front(); ev = 1'b1; ed = e.data; ee = ee | e.err;
            end
            compare({n, ".rvalid"}, {31'b0, a_rvalid}, {31'b0, ev});
            compare({n, ".rdata"},  a_rdata, ed);
            compare({n, ".err"},    {31'b0, a_err}, {31'b0, ee});
            compare({n, ".rd_cnt"}, {16'b0, a_rd_cnt}, mdl_rd[0]);
            compare({n, ".wr_cnt"}, {16'b0, a_wr_cnt}, mdl_wr[0]);
        end else begin
            if (q_b.size() > 0 && q_b[0].due == edge_n) begin
                e = q_b.pop_front(); ev = 1'b1; ed = e.data; ee = ee | e.err;
            end
            compare({n, ".rvalid"}, {31'b0, b_rvalid}, {31'b0, ev});
            compare({n, ".rdata"},  b_rdata, ed);
            compare({n, ".err"},    {31'b0, b_err}, {31'b0, ee});
            compare({n, ".rd_cnt"}, {16'b0, b_rd_cnt}, mdl_rd[1]);
            compare({n, ".wr_cnt"}, {16'b0, b_wr_cnt}, mdl_wr[1]);
        end
    endtask

    task automatic applyStimulus(input logic rst_v, input logic re_v, input logic [31:0] ra,
                                 input logic we_v, input logic [31:0] wa,
                                 input logic [31:0] wd, input logic [3:0] ws);
        rst_n = rst_v; re = re_v; raddr = ra; we = we_v; waddr = wa; wdata = wd; wstrb = ws;
        modelEdge(0);
        modelEdge(1);
        @(posedge clk);
        @(negedge clk);
        checkOutput(0);
        checkOutput(1);
        edge_n++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, a, d, s);
    endtask

    task automatic rd(input logic [31:0] a);
        applyStimulus(1'b1, 1'b1, a, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired at edge %0d", edge_n);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n = 1'b0; re = 1'b0; we = 1'b0; raddr = '0; waddr = '0; wdata = '0; wstrb = '0;
        $display("[TB] reset");
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b1, 32'h0, 32'h5555_5555, 4'hF);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);

        $display("[TB] initialise words");
        wr(32'h00, 32'hA0A0_A0A0, 4'hF);
        wr(32'h04, 32'hB1B1_B1B1, 4'hF);
        wr(32'h08, 32'hC2C2_C2C2, 4'hF);
        wr(32'h0C, 32'hD3D3_D3D3, 4'hF);
        wr(32'h10, 32'hE4E4_E4E4, 4'hF);
        wr(32'h3C, 32'h0000_0000, 4'hF);
        wr(32'h40, 32'h0000_0000, 4'hF);
        idle(2);

        $display("[TB] full write then read");
        wr(32'h100, 32'hDEAD_BEEF, 4'hF);
        rd(32'h100);
        idle(4);

        $display("[TB] partial strobes");
        wr(32'h200, 32'h1122_3344, 4'hF);
        wr(32'h20,  32'h1122_3344, 4'hF);
        wr(32'h200, 32'hAABB_CCDD, 4'b0101);
        wr(32'h20,  32'hAABB_CCDD, 4'b0101);
        rd(32'h200);
        rd(32'h20);
        wr(32'h20, 32'h9999_9999, 4'b0000);
        rd(32'h20);
        idle(4);

        $display("[TB] same-cycle write and read");
        applyStimulus(1'b1, 1'b1, 32'h3C, 1'b1, 32'h3C, 32'hFFFF_0000, 4'b1100);
        applyStimulus(1'b1, 1'b1, 32'h40, 1'b1, 32'h40, 32'hFFFF_0000, 4'b1100);
        rd(32'h3C);
        rd(32'h40);
        wr(32'h3C, 32'h1234_5678, 4'hF);
        applyStimulus(1'b1, 1'b1, 32'h3C, 1'b1, 32'h3C, 32'hAABB_CCDD, 4'b0011);
        applyStimulus(1'b1, 1'b1, 32'h0C, 1'b1, 32'h08, 32'h7777_7777, 4'hF);
        rd(32'h3C);
        idle(4);

        $display("[TB] back-to-back reads with writes behind them");
        rd(32'h00);
        applyStimulus(1'b1, 1'b1, 32'h04, 1'b1, 32'h04, 32'h4444_4444, 4'hF);
        applyStimulus(1'b1, 1'b1, 32'h08, 1'b1, 32'h00, 32'h0F0F_0F0F, 4'hF);
        rd(32'h04);
        rd(32'h00);
        idle(4);

        $display("[TB] out-of-range accesses");
        wr(32'hFFFF_FFFC, 32'h1, 4'hF);
        rd(32'hFFFF_FFFC);
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1, 32'hFFFF_FFFC, 32'h2, 4'hF);
        idle(4);

        $display("[TB] reset with a read in flight");
        rd(32'h100);
        applyStimulus(1'b0, 1'b1, 32'h04, 1'b1, 32'h00, 32'h5A5A_5A5A, 4'hF);
        idle(4);
        rd(32'h00);
        rd(32'h100);
        rd(32'h3C);
        idle(4);

        $display("[TB] counter saturation");
        for (int i = 0; i < 65540; i++)
            applyStimulus(1'b1, 1'b1, 32'h10, 1'b1, 32'h14, i, 4'hF);
        rd(32'h14);
        wr(32'h18, 32'h6, 4'hF);
        idle(5);

        compare("a.queue_drained", q_a.size(), 32'd0);
        compare("b.queue_drained", q_b.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
